ecg_parse_seq: RTL and testbench
================================

// Module: ecg_parse_seq
// PURPOSE
//  Sequencer for the combinational ECG parser (parse_ecg datapath): owns a bit-aligned substream buffer,
//  presents a 128-bit MSB-first window plus ecg_idx/ecNumSample, consumes parser numbits, steps all
//  ECGs of all components of one block, one ECG per cycle. Sits between substream bit FIFO and coeff dequant.
// PARAMETERS
//  NUM_COMP     3    components per block (1..4)
//  NUM_ECG      4    ECGs per component
//  BUF_W        192  shift-buffer width in bits (>=128+32)
//  MAX_ECG_BITS 80   worst-case bits one ECG consumes (1+9+7*10); min level before a parse
// PORTS
//  clk          in  1    clock
//  rst          in  1    synchronous, active-high reset
//  start        in  1    pulse: begin one block; ignored unless IDLE
//  mode_xfm     in  1    sampled on start; selects ECG sample table
//  bs_data      in  32   substream word, MSB first
//  bs_valid     in  1    word valid
//  bs_last      in  1    with bs_valid: final word of substream (no more refill)
//  bs_ready     out 1    word accepted when bs_valid&bs_ready
//  win          out 128  buf[BUF_W-1 -: 128]; bits beyond level forced 0
//  ecg_idx      out 3    current ECG index to parser
//  ec_num_smp   out 3    current ECG sample count to parser
//  xfm          out 1    latched mode_xfm to parser
//  numbits      in  8    parser consumption for current window (combinational, same cycle)
//  ecg_vld      out 1    1-cycle: parser outputs valid this cycle; downstream samples coeffs/signs now
//  comp_idx     out 2    component of current ECG
//  busy         out 1    not IDLE
//  done         out 1    1-cycle pulse after last ECG of block
//  err          out 1    sticky: numbits>level or numbits>MAX_ECG_BITS; cleared by rst only
// BEHAVIOUR
//  Reset: state=IDLE, level=0, buf=0, all outputs 0 (bs_ready=1 from reset, buffer fills while IDLE).
//  Buffer: level 0..BUF_W. bs_ready = (level <= BUF_W-32) & ~eos. Accepted word written at bit BUF_W-1-level.
//  eos set by accepted bs_last; cleared on start.
//  Same-cycle consume+refill: level_next = level - numbits + 32; word lands at post-shift position.
//  FSM: IDLE -start-> FILL. FILL -> PARSE when level>=MAX_ECG_BITS or eos.
//   PARSE: ecg_vld=1 for exactly one cycle per ECG; buffer left-shifts by numbits at edge; advance ecg_idx,
//   wrap to 0 and incr comp_idx after NUM_ECG-1; after last (comp NUM_COMP-1, ecg NUM_ECG-1) -> DONE.
//   PARSE stays PARSE while level-numbits>=MAX_ECG_BITS or eos; else -> FILL (no ecg_vld in FILL).
//   DONE: done=1 one cycle -> IDLE; comp_idx/ecg_idx return 0.
//  Throughput 1 ECG/cycle when refill keeps pace; sustained refill 32 b/cycle.
//  Sample table (package const): xfm -> {1,5,5,5}; non-xfm -> {4,4,4,4}; index by ecg_idx.
//  Error: in PARSE, numbits>level or >MAX_ECG_BITS sets err, consumes min(numbits,level); sequencing continues.
//  eos & level==0 in PARSE: ecg_vld still issued with zero window (parser sees all-zero = skip groups).
//  start while busy ignored. rst mid-block: immediate IDLE, buffer flushed, eos cleared.
// CONFIGURATION
//  ECG_SEQ_PERF_EN defined: adds out perf_stall[15:0], counts cycles in FILL while busy, saturates at
//   16'hFFFF, clears on start. Undefined: port absent, no counter logic.
// STRUCTURE
//  Package ecg_seq_pkg: state enum {IDLE,FILL,PARSE,DONE}, sample tables XFM_SMP/BP_SMP, MAX_ECG_BITS.
//  Sub-module ecg_bit_buf: shift buffer, level, bs_ready, consume/refill; FSM and counters in top.
//  parse_ecg not instantiated here; connected at parent level.
// TESTING
//  T1 reset mid-PARSE (rst at 3rd ECG) -> next cycle busy=0, level=0, ecg_vld=0, err=0.
//  T2 xfm=1, 4 words streamed, parser model numbits=1 every ECG -> 12 ecg_vld pulses, ec_num_smp 1,5,5,5
//   per comp, done 1 cycle after 12th, level drops by 12.
//  T3 numbits=80 every ECG, bs_valid held high -> FILL stalls between ECGs; total ECGs 12; bs_ready drops at
//   level>160; (PERF_EN) perf_stall equals counted FILL cycles.
//  T4 simultaneous consume 10 + refill word at level 100 -> level 122, win MSBs = old buf<<10 with new word
//   at bit 191-90.
//  T5 bs_last after 2 words (64 bits), numbits=8 -> PARSE runs on eos, 8 ECGs clean, 9th sees zero window,
//   no err; numbits=9 when level=8 -> err=1 sticky.
//  T6 start pulsed while busy -> ignored, ECG sequence unchanged.

Source files
------------

// File: rtl/ecg_seq_pkg.sv
// Shared constants for the ECG parse sequencer: FSM state codes, per-ECG sample tables
// and the worst-case ECG size used as the buffer low-water mark.
package ecg_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t FILL  = 2'd1;
    localparam state_t PARSE = 2'd2;
    localparam state_t DONE  = 2'd3;

    localparam int MAX_ECG_BITS = 80;
    localparam int LVL_W        = 8;

    // Entry [i] is the sample count of ECG i.
    localparam logic [3:0][2:0] XFM_SMP = {3'd5, 3'd5, 3'd5, 3'd1};
    localparam logic [3:0][2:0] BP_SMP  = {3'd4, 3'd4, 3'd4, 3'd4};

    function automatic logic [2:0] ecg_num_smp(input logic xfm, input logic [1:0] idx);
        return xfm ? XFM_SMP[idx] : BP_SMP[idx];
    endfunction

endpackage

// File: rtl/ecg_parse_seq_if.sv
// Substream word handshake between the bit FIFO (master) and the sequencer buffer (slave).
interface ecg_parse_seq_if;

    logic [31:0] bs_data;
    logic        bs_valid;
    logic        bs_last;
    logic        bs_ready;

    modport master (output bs_data, bs_valid, bs_last, input bs_ready);
    modport slave  (input bs_data, bs_valid, bs_last, output bs_ready);

endinterface

// File: rtl/ecg_bit_buf.sv
// MSB-aligned substream shift buffer: consumes parser bits and appends 32-bit words in the
// same cycle, tracks fill level and end-of-substream, and presents a zero-padded 128-bit window.
module ecg_bit_buf
    import ecg_seq_pkg::*;
#(
    parameter int BUF_W = 192
) (
    input  logic                 clk,
    input  logic                 rst,
    ecg_parse_seq_if.slave       bs,
    input  logic                 clear_eos,
    input  logic                 cons_en,
    input  logic [LVL_W-1:0]     cons_bits,
    output logic [LVL_W-1:0]     level,
    output logic                 eos,
    output logic [127:0]         win
);

    localparam logic [LVL_W-1:0] READY_MAX = LVL_W'(BUF_W - 32);
    localparam logic [LVL_W-1:0] WIN_BITS  = LVL_W'(128);

    logic [BUF_W-1:0] sbuf_q, sbuf_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] level_mid, shift;
    logic             eos_q, eos_d;
    logic             accept;
    logic [127:0]     top_bits, win_mask;

    assign bs.bs_ready = (level_q <= READY_MAX) && !eos_q;
    assign accept      = bs.bs_valid && bs.bs_ready;

    // The incoming word is placed after the shift so consume and refill compose in one cycle.
    always_comb begin
        shift     = cons_en ? cons_bits : '0;
        level_mid = level_q - shift;
        sbuf_d    = sbuf_q << shift;
        level_d   = level_mid;
        eos_d     = eos_q && !clear_eos;
        if (accept) begin
            sbuf_d  = sbuf_d | ({bs.bs_data, {(BUF_W-32){1'b0}}} >> level_mid);
            level_d = level_mid + LVL_W'(32);
            eos_d   = eos_d || bs.bs_last;
        end
    end

    always_comb begin
        top_bits = sbuf_q[BUF_W-1 -: 128];
        win_mask = (level_q >= WIN_BITS) ? '1 : ~({128{1'b1}} >> level_q);
        win      = top_bits & win_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sbuf_q  <= '0;
            level_q <= '0;
            eos_q   <= 1'b0;
        end else begin
            sbuf_q  <= sbuf_d;
            level_q <= level_d;
            eos_q   <= eos_d;
        end
    end

    assign level = level_q;
    assign eos   = eos_q;

endmodule

// File: rtl/ecg_parse_seq.sv
// ECG parse sequencer: walks every ECG of every component of a block, one per cycle, feeding
// the external parser from ecg_bit_buf. Define ECG_SEQ_PERF_EN to add the perf_stall counter.
module ecg_parse_seq #(
    parameter int NUM_COMP     = 3,
    parameter int NUM_ECG      = 4,
    parameter int BUF_W        = 192,
    parameter int MAX_ECG_BITS = ecg_seq_pkg::MAX_ECG_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode_xfm,
    ecg_parse_seq_if.slave  bs,
    output logic [127:0]    win,
    output logic [2:0]      ecg_idx,
    output logic [2:0]      ec_num_smp,
    output logic            xfm,
    input  logic [7:0]      numbits,
    output logic            ecg_vld,
    output logic [1:0]      comp_idx,
    output logic            busy,
    output logic            done,
    output logic            err
`ifdef ECG_SEQ_PERF_EN
    ,
    output logic [15:0]     perf_stall
`endif
);

    import ecg_seq_pkg::*;

    localparam logic [7:0] MAX_B = 8'(MAX_ECG_BITS);

    state_t     state_q, state_d;
    logic [1:0] comp_q, comp_d;
    logic [2:0] ecg_q, ecg_d;
    logic       xfm_q, xfm_d;
    logic       err_q, err_d;
    logic [7:0] level, cons_bits;
    logic       eos, clear_eos, cons_en, last_ecg, over_lvl;

    ecg_bit_buf #(.BUF_W(BUF_W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .bs        (bs),
        .clear_eos (clear_eos),
        .cons_en   (cons_en),
        .cons_bits (cons_bits),
        .level     (level),
        .eos       (eos),
        .win       (win)
    );

    assign last_ecg  = (comp_q == 2'(NUM_COMP - 1)) && (ecg_q == 3'(NUM_ECG - 1));
    assign over_lvl  = numbits > level;
    assign cons_bits = over_lvl ? level : numbits;

    // Once the substream has ended, PARSE never waits for data: the parser sees zeros.
    always_comb begin
        state_d   = state_q;
        comp_d    = comp_q;
        ecg_d     = ecg_q;
        xfm_d     = xfm_q;
        err_d     = err_q;
        clear_eos = 1'b0;
        cons_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FILL;
                    xfm_d     = mode_xfm;
                    clear_eos = 1'b1;
                    comp_d    = '0;
                    ecg_d     = '0;
                end
            end
            FILL: begin
                if (level >= MAX_B || eos) begin
                    state_d = PARSE;
                end
            end
            PARSE: begin
                cons_en = 1'b1;
                if (over_lvl || numbits > MAX_B) begin
                    err_d = 1'b1;
                end
                if (last_ecg) begin
                    state_d = DONE;
                    comp_d  = '0;
                    ecg_d   = '0;
                end else begin
                    if (ecg_q == 3'(NUM_ECG - 1)) begin
                        ecg_d  = '0;
                        comp_d = comp_q + 2'd1;
                    end else begin
                        ecg_d = ecg_q + 3'd1;
                    end
                    if (!((level - cons_bits) >= MAX_B || eos)) begin
                        state_d = FILL;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                comp_d  = '0;
                ecg_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            comp_q  <= '0;
            ecg_q   <= '0;
            xfm_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            comp_q  <= comp_d;
            ecg_q   <= ecg_d;
            xfm_q   <= xfm_d;
            err_q   <= err_d;
        end
    end

    assign ecg_vld    = (state_q == PARSE);
    assign done       = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign ecg_idx    = ecg_q;
    assign comp_idx   = comp_q;
    assign xfm        = xfm_q;
    assign err        = err_q;
    assign ec_num_smp = busy ? ecg_num_smp(xfm_q, ecg_q[1:0]) : 3'd0;

`ifdef ECG_SEQ_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == IDLE && start) begin
            perf_d = '0;
        end else if (state_q == FILL && perf_q != 16'hFFFF) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall = perf_q;
`endif

endmodule

// File: tb/tb_ecg_parse_seq.sv
// Directed bench for ecg_parse_seq: a vector table for a full xfm block plus hand-written
// sequences for consume+refill, refill stalls, end-of-substream, errors and mid-block reset.
module tb_ecg_parse_seq;

    typedef struct {
        logic        st;
        logic        mx;
        logic        v;
        logic [31:0] d;
        logic [7:0]  nb;
        logic        busy;
        logic        vld;
        logic        dn;
        logic [2:0]  ei;
        logic [1:0]  ci;
        logic [2:0]  smp;
        logic        rdy;
        logic [7:0]  lvl;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode_xfm;
    logic [7:0]   numbits;
    logic [127:0] win;
    logic [2:0]   ecg_idx;
    logic [2:0]   ec_num_smp;
    logic         xfm;
    logic         ecg_vld;
    logic [1:0]   comp_idx;
    logic         busy;
    logic         done;
    logic         err;
    logic [7:0]   lvl;
`ifdef ECG_SEQ_PERF_EN
    logic [15:0]  perf_stall;
`endif

    int check_count = 0;
    int err_count   = 0;

    ecg_parse_seq_if bsif ();

    ecg_parse_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode_xfm   (mode_xfm),
        .bs         (bsif),
        .win        (win),
        .ecg_idx    (ecg_idx),
        .ec_num_smp (ec_num_smp),
        .xfm        (xfm),
        .numbits    (numbits),
        .ecg_vld    (ecg_vld),
        .comp_idx   (comp_idx),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef ECG_SEQ_PERF_EN
        ,
        .perf_stall (perf_stall)
`endif
    );

    assign lvl = dut.u_buf.level_q;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        check_count++;
        if (act !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic mx, input logic v,
                                 input logic [31:0] d, input logic last, input logic [7:0] nb);
        start          = st;
        mode_xfm       = mx;
        bsif.bs_valid  = v;
        bsif.bs_data   = d;
        bsif.bs_last   = last;
        numbits        = nb;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic st, input logic mx, input logic v, input logic [31:0] d,
                                input logic [7:0] nb, input logic bsy, input logic vl, input logic dn,
                                input logic [2:0] ei, input logic [1:0] ci, input logic [2:0] smp,
                                input logic rdy, input logic [7:0] lv);
        vec_t r;
        r.st = st;   r.mx = mx;   r.v = v;     r.d = d;     r.nb = nb;
        r.busy = bsy; r.vld = vl; r.dn = dn;   r.ei = ei;   r.ci = ci;
        r.smp = smp; r.rdy = rdy; r.lvl = lv;
        return r;
    endfunction

    logic [31:0]  words [5];
    logic [127:0] s128;
    logic [127:0] s64;
    vec_t         tbl [19];
    int           cnt;
    int           fill_cnt;
    logic [7:0]   nb;

    initial begin
        words[0] = 32'hDEADBEEF;
        words[1] = 32'h12345678;
        words[2] = 32'hA5A5C3C3;
        words[3] = 32'h0F1E2D3C;
        words[4] = 32'hCAFEF00D;
        s128 = {words[0], words[1], words[2], words[3]};
        s64  = {words[0], words[1], 64'h0};

        // xfm block, preloaded with 128 bits, parser eats 1 bit per ECG.
        for (int i = 0; i < 4; i++) begin
            tbl[i] = mk(1'b0, 1'b0, 1'b1, words[i], 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 3'd0, 1'b1, 8'(32 * (i + 1)));
        end
        tbl[4] = mk(1'b1, 1'b1, 1'b0, 32'h0, 8'd0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 3'd1, 1'b1, 8'd128);
        tbl[5] = mk(1'b0, 1'b0, 1'b0, 32'h0, 8'd0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 3'd1, 1'b1, 8'd128);
        for (int k = 1; k < 12; k++) begin
            tbl[5 + k] = mk(1'b0, 1'b0, 1'b0, 32'h0, 8'd1, 1'b1, 1'b1, 1'b0, 3'(k % 4), 2'(k / 4),
                            (k % 4 == 0) ? 3'd1 : 3'd5, 1'b1, 8'(128 - k));
        end
        tbl[17] = mk(1'b0, 1'b0, 1'b0, 32'h0, 8'd1, 1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 3'd1, 1'b1, 8'd116);
        tbl[18] = mk(1'b0, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 3'd0, 1'b1, 8'd116);

        rst = 1'b1;
        doReset();
        checkOutput("reset busy", 128'(busy), 128'd0);
        checkOutput("reset ecg_vld", 128'(ecg_vld), 128'd0);
        checkOutput("reset done", 128'(done), 128'd0);
        checkOutput("reset err", 128'(err), 128'd0);
        checkOutput("reset bs_ready", 128'(bsif.bs_ready), 128'd1);
        checkOutput("reset win", win, 128'd0);
        checkOutput("reset level", 128'(lvl), 128'd0);
        checkOutput("reset ec_num_smp", 128'(ec_num_smp), 128'd0);

        // Full block from the vector table
        for (int i = 0; i < 19; i++) begin
            applyStimulus(tbl[i].st, tbl[i].mx, tbl[i].v, tbl[i].d, 1'b0, tbl[i].nb);
            tick();
            checkOutput($sformatf("t2 row%0d busy", i), 128'(busy), 128'(tbl[i].busy));
            checkOutput($sformatf("t2 row%0d ecg_vld", i), 128'(ecg_vld), 128'(tbl[i].vld));
            checkOutput($sformatf("t2 row%0d done", i), 128'(done), 128'(tbl[i].dn));
            checkOutput($sformatf("t2 row%0d ecg_idx", i), 128'(ecg_idx), 128'(tbl[i].ei));
            checkOutput($sformatf("t2 row%0d comp_idx", i), 128'(comp_idx), 128'(tbl[i].ci));
            checkOutput($sformatf("t2 row%0d ec_num_smp", i), 128'(ec_num_smp), 128'(tbl[i].smp));
            checkOutput($sformatf("t2 row%0d bs_ready", i), 128'(bsif.bs_ready), 128'(tbl[i].rdy));
            checkOutput($sformatf("t2 row%0d level", i), 128'(lvl), 128'(tbl[i].lvl));
            if (i == 3)  checkOutput("t2 win full", win, s128);
            if (i == 6)  checkOutput("t2 win shift1", win, s128 << 1);
            if (i == 16) checkOutput("t2 win shift11", win, s128 << 11);
        end
        checkOutput("t2 xfm latched", 128'(dut.xfm_q), 128'd1);

        // Consume 10 and refill a word in the same cycle, then a start while busy
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, words[i], 1'b0, 8'd0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        tick();
        checkOutput("t4 ecg0 vld", 128'(ecg_vld), 128'd1);
        checkOutput("t4 ecg0 smp", 128'(ec_num_smp), 128'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd28);
        tick();
        checkOutput("t4 level 100", 128'(lvl), 128'd100);
        checkOutput("t4 win at 100", win, {s128[99:0], 28'h0});
        applyStimulus(1'b0, 1'b0, 1'b1, words[4], 1'b0, 8'd10);
        tick();
        checkOutput("t4 level 122", 128'(lvl), 128'd122);
        checkOutput("t4 win refill", win, {s128[89:0], words[4], 6'h0});
        checkOutput("t4 ecg_idx", 128'(ecg_idx), 128'd2);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 8'd0);
        tick();
        checkOutput("t6 ecg_idx", 128'(ecg_idx), 128'd3);
        checkOutput("t6 xfm kept", 128'(xfm), 128'd0);
        checkOutput("t6 busy", 128'(busy), 128'd1);
        checkOutput("t6 ecg_vld", 128'(ecg_vld), 128'd1);
        checkOutput("t6 level", 128'(lvl), 128'd122);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        cnt = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            if (ecg_vld) cnt++;
            tick();
        end
        checkOutput("t6 done seen", 128'(done), 128'd1);
        checkOutput("t6 remaining ecgs", 128'(cnt), 128'd9);
        tick();
        checkOutput("t6 idle", 128'(busy), 128'd0);
        checkOutput("t6 comp_idx zero", 128'(comp_idx), 128'd0);

        // 80 bits per ECG with a full buffer and bs_valid held high
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h1000_0000 + 32'(i), 1'b0, 8'd0);
            tick();
            if (i == 4) begin
                checkOutput("t3 ready at 160", 128'(bsif.bs_ready), 128'd1);
                checkOutput("t3 level 160", 128'(lvl), 128'd160);
            end
        end
        checkOutput("t3 ready at 192", 128'(bsif.bs_ready), 128'd0);
        checkOutput("t3 level 192", 128'(lvl), 128'd192);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h2000_0000, 1'b0, 8'd80);
        tick();
        cnt = 0;
        fill_cnt = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            if (ecg_vld) cnt++;
            else fill_cnt++;
            bsif.bs_data = bsif.bs_data + 32'd1;
            tick();
        end
        checkOutput("t3 done seen", 128'(done), 128'd1);
        checkOutput("t3 ecg count", 128'(cnt), 128'd12);
        checkOutput("t3 fill cycles", 128'(fill_cnt), 128'd16);
        checkOutput("t3 final level", 128'(lvl), 128'd64);
        checkOutput("t3 err", 128'(err), 128'd0);
`ifdef ECG_SEQ_PERF_EN
        checkOutput("t3 perf_stall", 128'(perf_stall), 128'd16);
`endif

        // End of substream after 64 bits: parser sees a zero window once data runs out
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, words[0], 1'b0, 8'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, words[1], 1'b1, 8'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        tick();
        checkOutput("t5 parse on eos", 128'(ecg_vld), 128'd1);
        checkOutput("t5 ready after last", 128'(bsif.bs_ready), 128'd0);
        checkOutput("t5 level 64", 128'(lvl), 128'd64);
        for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("t5 ecg%0d vld", k), 128'(ecg_vld), 128'd1);
            if (k <= 8) checkOutput($sformatf("t5 ecg%0d win", k), win, s64 << (8 * k));
            nb = (k < 8) ? 8'd8 : 8'd0;
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, nb);
            tick();
        end
        checkOutput("t5 done", 128'(done), 128'd1);
        checkOutput("t5 no err", 128'(err), 128'd0);
        checkOutput("t5 level 0", 128'(lvl), 128'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        tick();
        checkOutput("t5 eos cleared", 128'(bsif.bs_ready), 128'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, words[0], 1'b0, 8'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, words[1], 1'b1, 8'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        tick();
        for (int k = 0; k < 12; k++) begin
            nb = (k < 7) ? 8'd8 : ((k == 7) ? 8'd9 : 8'd0);
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, nb);
            tick();
            if (k == 6) checkOutput("t5 no err before overrun", 128'(err), 128'd0);
            if (k == 7) begin
                checkOutput("t5 err on overrun", 128'(err), 128'd1);
                checkOutput("t5 level clamped", 128'(lvl), 128'd0);
            end
        end
        checkOutput("t5 done after err", 128'(done), 128'd1);
        checkOutput("t5 err sticky", 128'(err), 128'd1);

        // Reset in the middle of a block, at the third ECG
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h5555AAAA, 1'b0, 8'd1);
        for (int n = 0; n < 40 && !(ecg_vld && ecg_idx == 3'd2); n++) begin
            tick();
        end
        checkOutput("t1 reached ecg2", 128'(ecg_vld && ecg_idx == 3'd2), 128'd1);
        checkOutput("t1 err before reset", 128'(err), 128'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        rst = 1'b1;
        tick();
        checkOutput("t1 busy", 128'(busy), 128'd0);
        checkOutput("t1 level", 128'(lvl), 128'd0);
        checkOutput("t1 ecg_vld", 128'(ecg_vld), 128'd0);
        checkOutput("t1 err", 128'(err), 128'd0);
        checkOutput("t1 bs_ready", 128'(bsif.bs_ready), 128'd1);
        checkOutput("t1 win", win, 128'd0);
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", check_count, err_count);
        $finish;
    end

endmodule
